// File: rtl/nicotb_sink_pkg.sv
// rtl/nicotb_sink_pkg.sv - shared types and LFSR helper for the two-wire stream sink
package nicotb_sink_pkg;

    typedef enum logic [1:0] {
        MODE_ALWAYS = 2'd0,
        MODE_NEVER  = 2'd1,
        MODE_RAND   = 2'd2,
        MODE_PERIOD = 2'd3
    } ready_mode_e;

    // Taps 16,14,13,11 counted from the output end: bits 0,2,3,5 of a right-shifting register.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/nicotb_sync_fifo.sv
// rtl/nicotb_sync_fifo.sv - single-clock FIFO with occupancy counter and underflow-safe pop
module nicotb_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [DW-1:0]            i_data,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [DW-1:0]            o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    // Pop on empty is dropped; push is guarded here too so the FIFO is safe standalone.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && !o_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nicotb_twowire_sink.sv
// rtl/nicotb_twowire_sink.sv - valid/ready responder with backpressure patterns and beat capture
module nicotb_twowire_sink
    import nicotb_sink_pkg::*;
#(
    parameter int          DW    = 8,
    parameter int          DEPTH = 4,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [DW-1:0]            i_data,
    output logic                     o_ready,
    input  logic [1:0]               cfg_mode,
    input  logic [7:0]               cfg_thresh,
    output logic                     o_cap,
    output logic [DW-1:0]            o_cap_data,
    input  logic                     i_pop,
    output logic [DW-1:0]            o_head,
    output logic                     o_nempty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [31:0]              o_beats
);
    logic [15:0]   r_lfsr;
    logic [7:0]    r_per;
    logic          r_cap;
    logic [DW-1:0] r_cap_data;
    logic [31:0]   r_beats;

    logic [7:0]    w_period;
    logic          w_pattern;
    logic          w_full;
    logic          w_empty;
    logic          w_acc;

    always_comb begin
        w_period  = (cfg_thresh == 8'd0) ? 8'd1 : cfg_thresh;
        w_pattern = 1'b0;
        case (ready_mode_e'(cfg_mode))
            MODE_ALWAYS: w_pattern = 1'b1;
            MODE_NEVER:  w_pattern = 1'b0;
            MODE_RAND:   w_pattern = (r_lfsr[7:0] < cfg_thresh);
            MODE_PERIOD: w_pattern = (r_per == 8'd0);
            default:     w_pattern = 1'b0;
        endcase
    end

    // Ready never looks at i_valid; rst gating keeps a coincident beat from being taken.
    assign o_ready = w_pattern && !w_full && !rst;
    assign w_acc   = i_valid && o_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr     <= SEED;
            r_per      <= 8'd0;
            r_cap      <= 1'b0;
            r_cap_data <= '0;
            r_beats    <= 32'd0;
        end else begin
            r_lfsr <= lfsr16_next(r_lfsr);
            // The >= compare also clamps a counter left beyond a newly shortened period.
            r_per  <= (r_per >= w_period - 8'd1) ? 8'd0 : r_per + 8'd1;
            r_cap  <= w_acc;
            if (w_acc) begin
                r_cap_data <= i_data;
                r_beats    <= r_beats + 32'd1;
            end
        end
    end

    assign o_cap      = r_cap;
    assign o_cap_data = r_cap_data;
    assign o_beats    = r_beats;
    assign o_nempty   = !w_empty;

    nicotb_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_acc),
        .i_data  (i_data),
        .i_pop   (i_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_count),
        .o_head  (o_head)
    );

endmodule

// File: tb/tb_nicotb_twowire_sink.sv
// tb/tb_nicotb_twowire_sink.sv - scoreboard bench for the two-wire stream sink
module tb_nicotb_twowire_sink;
    localparam int          DW    = 8;
    localparam int          DEPTH = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_ready;
    logic [1:0]    cfg_mode = 2'd0;
    logic [7:0]    cfg_thresh = 8'd0;
    logic          o_cap;
    logic [DW-1:0] o_cap_data;
    logic          i_pop = 1'b0;
    logic [DW-1:0] o_head;
    logic          o_nempty;
    logic [2:0]    o_count;
    logic [31:0]   o_beats;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_lfsr;
    int          m_per;
    logic [7:0]  m_fifo[$];
    logic [7:0]  cap_q[$];
    logic        m_cap;
    logic [31:0] m_beats;

    nicotb_twowire_sink #(.DW(DW), .DEPTH(DEPTH), .SEED(SEED)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .cfg_mode   (cfg_mode),
        .cfg_thresh (cfg_thresh),
        .o_cap      (o_cap),
        .o_cap_data (o_cap_data),
        .i_pop      (i_pop),
        .o_head     (o_head),
        .o_nempty   (o_nempty),
        .o_count    (o_count),
        .o_beats    (o_beats)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        logic [15:0] b;
        b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
        return (s >> 1) | (b << 15);
    endfunction

    function automatic logic ref_pattern();
        case (cfg_mode)
            2'd0:    return 1'b1;
            2'd1:    return 1'b0;
            2'd2:    return m_lfsr[7:0] < cfg_thresh;
            default: return m_per == 0;
        endcase
    endfunction

    task automatic model_reset();
        m_lfsr  = SEED;
        m_per   = 0;
        m_fifo.delete();
        cap_q.delete();
        m_cap   = 1'b0;
        m_beats = 32'd0;
    endtask

    // Called #1 after a posedge; checks the DUT at the negedge, then advances the model.
    task automatic cycle(input logic v, input logic [7:0] d, input logic p);
        logic exp_rdy;
        logic acc;
        logic pop_eff;
        int   n;
        i_valid = v;
        i_data  = d;
        i_pop   = p;
        @(negedge clk);
        check_eq("cap", 32'(o_cap), 32'(m_cap));
        if (m_cap && cap_q.size() > 0) check_eq("cap_data", 32'(o_cap_data), 32'(cap_q.pop_front()));
        check_eq("count", 32'(o_count), 32'(m_fifo.size()));
        check_eq("nempty", 32'(o_nempty), 32'(m_fifo.size() != 0));
        if (m_fifo.size() > 0) check_eq("head", 32'(o_head), 32'(m_fifo[0]));
        check_eq("beats", o_beats, m_beats);
        exp_rdy = !rst && ref_pattern() && (m_fifo.size() < DEPTH);
        check_eq("ready", 32'(o_ready), 32'(exp_rdy));
        acc     = v && exp_rdy;
        pop_eff = p && (m_fifo.size() > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            m_lfsr = ref_lfsr(m_lfsr);
            n      = (cfg_thresh == 8'd0) ? 1 : int'(cfg_thresh);
            m_per  = (m_per + 1 >= n) ? 0 : m_per + 1;
            if (pop_eff) void'(m_fifo.pop_front());
            if (acc) begin
                m_fifo.push_back(d);
                cap_q.push_back(d);
                m_beats = m_beats + 32'd1;
            end
            m_cap = acc;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int in_range;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(o_ready), 32'd0);
        rst = 1'b0;
        check_eq("rst_count", 32'(o_count), 32'd0);
        check_eq("rst_nempty", 32'(o_nempty), 32'd0);
        check_eq("rst_cap", 32'(o_cap), 32'd0);
        check_eq("rst_cap_data", 32'(o_cap_data), 32'd0);
        check_eq("rst_beats", o_beats, 32'd0);

        // Fill to full in mode 0, hold a fifth beat until one pop frees a slot.
        cfg_mode = 2'd0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
        check_eq("t1_count_full", 32'(o_count), 32'd4);
        cycle(1'b1, 8'h14, 1'b0);
        cycle(1'b1, 8'h14, 1'b1);
        check_eq("t1_head_after_pop", 32'(o_head), 32'h11);
        cycle(1'b1, 8'h14, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("t1_beats", o_beats, 32'd5);

        // Mode 1 blocks everything; switching to mode 0 accepts in the same cycle.
        do_reset();
        cfg_mode = 2'd1;
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i), 1'b0);
        check_eq("t2_beats_never", o_beats, 32'd0);
        cfg_mode = 2'd0;
        cycle(1'b1, 8'h55, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("t2_beats_switch", o_beats, 32'd1);

        // Periodic, N=3, popping each cycle.
        cfg_mode   = 2'd3;
        cfg_thresh = 8'd3;
        do_reset();
        for (int i = 0; i < 30; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1);
        check_eq("t3_beats", o_beats, 32'd10);
        cfg_thresh = 8'd2;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(i), 1'b1);

        // Simultaneous push and pop with count 2, then on an empty FIFO.
        cfg_mode = 2'd0;
        do_reset();
        cycle(1'b1, 8'hA1, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0);
        cycle(1'b1, 8'hA3, 1'b1);
        check_eq("t5_count_2", 32'(o_count), 32'd2);
        check_eq("t5_head_order", 32'(o_head), 32'hA2);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("t5_underflow", 32'(o_count), 32'd0);
        cycle(1'b1, 8'hB0, 1'b1);
        check_eq("t5_count_1", 32'(o_count), 32'd1);
        check_eq("t5_head_push", 32'(o_head), 32'hB0);

        // Reset mid-stream with three captured beats and a valid beat on the reset edge.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        rst = 1'b1;
        cycle(1'b1, 8'h77, 1'b0);
        rst = 1'b0;
        check_eq("t6_count", 32'(o_count), 32'd0);
        check_eq("t6_nempty", 32'(o_nempty), 32'd0);
        check_eq("t6_beats", o_beats, 32'd0);
        check_eq("t6_cap", 32'(o_cap), 32'd0);

        // Random mode from a freshly reset LFSR.
        cfg_mode   = 2'd2;
        cfg_thresh = 8'd128;
        for (int i = 0; i < 1000; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
        in_range = (o_beats >= 32'd450 && o_beats <= 32'd550) ? 1 : 0;
        check_eq("t4_accept_range", 32'(in_range), 32'd1);
        cfg_thresh = 8'd0;
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i), 1'b1);
        cfg_thresh = 8'd255;
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(i), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
